// File: rtl/dac_pkg.sv
// Shared types and the default DAC configuration table for the init sequencer.
package dac_pkg;

    localparam int CMD_W     = 24;
    localparam int ADDR_W    = 7;
    localparam int DATA_W    = 16;
    localparam int IDX_W     = 8;
    localparam int TABLE_LEN = 4;

    typedef enum logic [2:0] {
        ST_RST_HOLD  = 3'd0,
        ST_PWR_WAIT  = 3'd1,
        ST_ISSUE     = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_GAP       = 3'd4,
        ST_DONE      = 3'd5,
        ST_ERR       = 3'd6
    } seq_state_e;

    // Command word layout: {write flag, register address, register data}
    typedef struct packed {
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } dac_cmd_t;

    localparam logic [CMD_W-1:0] INIT_TABLE [TABLE_LEN] = '{
        {1'b1, 7'h00, 16'h0001},
        {1'b1, 7'h02, 16'h8000},
        {1'b1, 7'h05, 16'h00FF},
        {1'b1, 7'h0A, 16'h1234}
    };

endpackage

// File: rtl/dac_init_rom.sv
// Combinational lookup of the configuration table; indices past the table read as zero.
module dac_init_rom
    import dac_pkg::*;
(
    input  logic [IDX_W-1:0] idx_i,
    output logic [CMD_W-1:0] word_o
);

    localparam int TAB_AW = (TABLE_LEN > 1) ? $clog2(TABLE_LEN) : 1;

    // Table read with out-of-range guard
    always_comb begin
        if (idx_i < IDX_W'(TABLE_LEN)) begin
            word_o = INIT_TABLE[idx_i[TAB_AW-1:0]];
        end else begin
            word_o = {CMD_W{1'b0}};
        end
    end

endmodule

// File: rtl/dac_init_seq.sv
// DAC power-up sequencer: hardware reset hold, power-up wait, then streams the
// configuration table to the SPI master and reports done or timeout.
module dac_init_seq
    import dac_pkg::*;
#(
    parameter int RST_HOLD_CYC   = 1000,
    parameter int PWRUP_WAIT_CYC = 5000,
    parameter int NUM_CMDS       = 4,
    parameter int GAP_CYC        = 16,
    parameter int TIMEOUT_CYC    = 4096
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             dac_rst_n,
    output logic [CMD_W-1:0] cmd_data,
    output logic             cmd_valid,
    input  logic             cmd_ready,
    input  logic             cmd_done,
    output logic             busy,
    output logic             init_done,
    output logic             init_err
);

    localparam int MAX_AB  = (RST_HOLD_CYC > PWRUP_WAIT_CYC) ? RST_HOLD_CYC : PWRUP_WAIT_CYC;
    localparam int MAX_CD  = (GAP_CYC > TIMEOUT_CYC) ? GAP_CYC : TIMEOUT_CYC;
    localparam int MAX_CYC = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CNT_W   = $clog2(MAX_CYC) + 1;

    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] PWR_LAST = CNT_W'(PWRUP_WAIT_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_CMDS - 1);
    localparam bit               NO_GAP   = (GAP_CYC == 0);

    seq_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             dac_rst_n_q, dac_rst_n_d;
    logic [CMD_W-1:0] cmd_data_q, cmd_data_d;
    logic             cmd_valid_q, cmd_valid_d;
    logic             busy_q, busy_d;
    logic             init_done_q, init_done_d;
    logic             init_err_q, init_err_d;
    logic [IDX_W-1:0] rom_idx_s;
    logic [CMD_W-1:0] rom_word_s;

    // WAIT_DONE may jump straight to ISSUE, so it must already see the next word
    assign rom_idx_s = (state_q == ST_WAIT_DONE) ? (idx_q + IDX_W'(1)) : idx_q;

    dac_init_rom u_rom (
        .idx_i  (rom_idx_s),
        .word_o (rom_word_s)
    );

    // Sequencer next-state and next-output logic
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        dac_rst_n_d = dac_rst_n_q;
        cmd_data_d  = cmd_data_q;
        cmd_valid_d = cmd_valid_q;
        busy_d      = busy_q;
        init_done_d = init_done_q;
        init_err_d  = init_err_q;
        case (state_q)
            ST_RST_HOLD: begin
                if (cnt_q == RST_LAST) begin
                    state_d     = ST_PWR_WAIT;
                    cnt_d       = {CNT_W{1'b0}};
                    dac_rst_n_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_PWR_WAIT: begin
                if (cnt_q == PWR_LAST) begin
                    state_d     = ST_ISSUE;
                    cmd_valid_d = 1'b1;
                    cmd_data_d  = rom_word_s;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_ISSUE: begin
                if (cmd_ready) begin
                    state_d     = ST_WAIT_DONE;
                    cmd_valid_d = 1'b0;
                    cnt_d       = {CNT_W{1'b0}};
                end else begin
                    cnt_d = cnt_q;
                end
            end
            ST_WAIT_DONE: begin
                // A completion arriving on the timeout cycle still counts as success
                if (cmd_done) begin
                    if (idx_q == IDX_LAST) begin
                        state_d     = ST_DONE;
                        busy_d      = 1'b0;
                        init_done_d = 1'b1;
                    end else if (NO_GAP) begin
                        state_d     = ST_ISSUE;
                        idx_d       = idx_q + IDX_W'(1);
                        cnt_d       = {CNT_W{1'b0}};
                        cmd_valid_d = 1'b1;
                        cmd_data_d  = rom_word_s;
                    end else begin
                        state_d = ST_GAP;
                        idx_d   = idx_q + IDX_W'(1);
                        cnt_d   = {CNT_W{1'b0}};
                    end
                end else if (cnt_q == TO_LAST) begin
                    state_d    = ST_ERR;
                    busy_d     = 1'b0;
                    init_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d     = ST_ISSUE;
                    cmd_valid_d = 1'b1;
                    cmd_data_d  = rom_word_s;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE, ST_ERR: begin
                if (start) begin
                    state_d     = ST_RST_HOLD;
                    cnt_d       = {CNT_W{1'b0}};
                    idx_d       = {IDX_W{1'b0}};
                    dac_rst_n_d = 1'b0;
                    busy_d      = 1'b1;
                    init_done_d = 1'b0;
                    init_err_d  = 1'b0;
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d     = ST_ERR;
                cmd_valid_d = 1'b0;
                busy_d      = 1'b0;
                init_done_d = 1'b0;
                init_err_d  = 1'b1;
            end
        endcase
    end

    // State and registered outputs; reset overrides everything
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RST_HOLD;
            cnt_q       <= {CNT_W{1'b0}};
            idx_q       <= {IDX_W{1'b0}};
            dac_rst_n_q <= 1'b0;
            cmd_data_q  <= {CMD_W{1'b0}};
            cmd_valid_q <= 1'b0;
            busy_q      <= 1'b1;
            init_done_q <= 1'b0;
            init_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            dac_rst_n_q <= dac_rst_n_d;
            cmd_data_q  <= cmd_data_d;
            cmd_valid_q <= cmd_valid_d;
            busy_q      <= busy_d;
            init_done_q <= init_done_d;
            init_err_q  <= init_err_d;
        end
    end

    assign dac_rst_n = dac_rst_n_q;
    assign cmd_data  = cmd_data_q;
    assign cmd_valid = cmd_valid_q;
    assign busy      = busy_q;
    assign init_done = init_done_q;
    assign init_err  = init_err_q;

endmodule

// File: tb/tb_dac_init_seq.sv
// Randomised bench for dac_init_seq with a timestamp-based reference model and an SPI responder.
module tb_dac_init_seq;

    localparam int RH = 4, PW = 8, GAP = 2, N_CMDS = 3, TO = 20;
    localparam logic [23:0] TBL [0:2] = '{24'h800001, 24'h828000, 24'h8500FF};

    logic        clk, rst, start, dac_rst_n, cmd_valid, cmd_ready, cmd_done;
    logic        busy, init_done, init_err;
    logic [23:0] cmd_data;

    dac_init_seq #(
        .RST_HOLD_CYC(RH), .PWRUP_WAIT_CYC(PW), .NUM_CMDS(N_CMDS),
        .GAP_CYC(GAP), .TIMEOUT_CYC(TO)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .dac_rst_n(dac_rst_n),
        .cmd_data(cmd_data), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_done(cmd_done), .busy(busy), .init_done(init_done), .init_err(init_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    int edge_n = 0;
    bit chk_en = 0;

    // Reference model: timestamps of when things must happen, not a state copy
    int m_trel = 0, m_toffer = 0, m_ths = 0, m_widx = 0, m_term = 0;
    bit m_offer = 0, m_inflight = 0;

    always @(posedge clk) begin
        edge_n <= edge_n + 1;
        if (rst) chk_en <= 1'b1;
        if (rst || (m_term != 0 && start)) begin
            m_term <= 0; m_offer <= 0; m_inflight <= 0; m_widx <= 0;
            m_trel <= edge_n + 1 + RH;
            m_toffer <= edge_n + 1 + RH + PW;
        end else if (m_term == 0) begin
            if (m_offer) begin
                if (cmd_ready) begin
                    m_offer <= 0; m_inflight <= 1; m_ths <= edge_n + 1;
                end
            end else if (m_inflight) begin
                if (cmd_done) begin
                    m_inflight <= 0;
                    if (m_widx == N_CMDS - 1) m_term <= 1;
                    else begin
                        m_widx <= m_widx + 1;
                        m_toffer <= edge_n + 1 + GAP;
                    end
                end else if (edge_n + 1 == m_ths + TO) begin
                    m_term <= 2; m_inflight <= 0;
                end
            end else if (edge_n + 1 == m_toffer) begin
                m_offer <= 1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, got, exp, edge_n);
        end
    endtask

    // Per-cycle comparison of every output against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("dac_rst_n", {31'd0, dac_rst_n}, {31'd0, (edge_n >= m_trel)});
            chk("cmd_valid", {31'd0, cmd_valid}, {31'd0, m_offer});
            if (m_offer) chk("cmd_data", {8'd0, cmd_data}, {8'd0, TBL[m_widx]});
            chk("busy", {31'd0, busy}, {31'd0, (m_term == 0)});
            chk("init_done", {31'd0, init_done}, {31'd0, (m_term == 1)});
            chk("init_err", {31'd0, init_err}, {31'd0, (m_term == 2)});
        end
    end

    // SPI responder state and knobs
    int rdy_delay = 0, done_lat = 5, withhold_n = -1;
    bit stray_en = 0, rand_delays = 0;
    int vcnt = 0, since_hs = 0, hs_cnt = 0, hs_e = 0, r0 = 0;
    bit pend_hs = 0, in_tx = 0;
    logic [23:0] got_q [$];

    task automatic resp_clear();
        in_tx = 0; pend_hs = 0; vcnt = 0; hs_cnt = 0; got_q.delete();
    endtask

    task automatic step();
        @(negedge clk);
        start = 1'b0; rst = 1'b0;
        if (pend_hs) begin pend_hs = 0; in_tx = 1; since_hs = 0; end
        else if (in_tx) since_hs++;
        if (cmd_valid) vcnt++; else vcnt = 0;
        cmd_done = 1'b0;
        if (in_tx && (withhold_n != hs_cnt - 1) && since_hs >= done_lat - 1) begin
            cmd_done = 1'b1; in_tx = 0;
        end else if (stray_en && !in_tx && $urandom_range(0, 5) == 0) begin
            cmd_done = 1'b1;
        end
        cmd_ready = 1'b0;
        if (cmd_valid && !in_tx && vcnt > rdy_delay) begin
            cmd_ready = 1'b1; pend_hs = 1; hs_cnt++;
            got_q.push_back(cmd_data);
            hs_e = edge_n + 1;
            if (rand_delays) begin
                rdy_delay = $urandom_range(0, 4);
                done_lat = $urandom_range(1, 6);
            end
        end else if (!cmd_valid && $urandom_range(0, 3) == 0) begin
            cmd_ready = 1'b1;
        end
        if (stray_en && m_term == 0 && $urandom_range(0, 7) == 0) start = 1'b1;
    endtask

    task automatic do_rst(input int n);
        for (int i = 0; i < n; i++) begin
            if (i > 0) @(negedge clk);
            rst = 1'b1; start = 1'b0; cmd_ready = 1'b0; cmd_done = 1'b0;
        end
        resp_clear();
        r0 = edge_n + 1;
    endtask

    task automatic do_start();
        resp_clear();
        start = 1'b1;
    endtask

    task automatic wait_for(input string name, input int which, input int budget, output int e);
        int n = 0;
        bit hit = 0;
        e = -1;
        while (!hit && n < budget) begin
            step();
            n++;
            case (which)
                0: hit = (dac_rst_n === 1'b1);
                1: hit = (cmd_valid === 1'b1);
                2: hit = (init_done === 1'b1);
                3: hit = (init_err === 1'b1);
                default: hit = (busy === 1'b0);
            endcase
        end
        if (hit) e = edge_n;
        else begin
            checks++; errors++;
            $display("FAIL %s: no event within %0d cycles", name, budget);
        end
    endtask

    task automatic check_words(input string name, input int n);
        chk({name, "_count"}, got_q.size(), n);
        for (int i = 0; i < got_q.size() && i < N_CMDS; i++)
            chk(name, {8'd0, got_q[i]}, {8'd0, TBL[i]});
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int e_rise, e_v, e_end, st_e, n_low, nv;
        bit unstable;
        logic [23:0] d0;
        rst = 1'b1; start = 1'b0; cmd_ready = 1'b0; cmd_done = 1'b0;

        // Power-up from reset with a fixed-latency SPI master
        do_rst(3);
        step();
        chk("reset_dac_rst_n", {31'd0, dac_rst_n}, 32'd0);
        chk("reset_cmd_valid", {31'd0, cmd_valid}, 32'd0);
        chk("reset_cmd_data", {8'd0, cmd_data}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd1);
        wait_for("t1_rise", 0, 50, e_rise);
        chk("t1_rst_hold_len", e_rise - r0, 32'd4);
        wait_for("t1_valid", 1, 50, e_v);
        chk("t1_pwrup_len", e_v - e_rise, 32'd8);
        wait_for("t1_done", 2, 200, e_end);
        check_words("t1_words", 3);
        chk("t1_busy_low", {31'd0, busy}, 32'd0);

        // Ready held low for 10 cycles on the first word
        rdy_delay = 10;
        do_start();
        wait_for("t2_valid", 1, 50, e_v);
        d0 = cmd_data; n_low = 0; unstable = 0;
        while (!pend_hs && n_low < 50) begin
            if (cmd_valid !== 1'b1 || cmd_data !== d0) unstable = 1;
            n_low++;
            step();
        end
        if (cmd_valid !== 1'b1 || cmd_data !== d0) unstable = 1;
        chk("t2_ready_low_cycles", n_low, 32'd10);
        chk("t2_offer_stable", {31'd0, unstable}, 32'd0);
        rand_delays = 1; rdy_delay = $urandom_range(0, 4);
        step();
        chk("t2_single_transfer", {31'd0, cmd_valid}, 32'd0);
        wait_for("t2_done", 2, 300, e_end);
        check_words("t2_words", 3);

        // Completion withheld on word 1 -> timeout
        rand_delays = 0; rdy_delay = 0; done_lat = 3; withhold_n = 1;
        do_start();
        wait_for("t3_err", 3, 300, e_end);
        chk("t3_timeout_len", e_end - hs_e, 32'd20);
        chk("t3_busy_low", {31'd0, busy}, 32'd0);
        nv = 0;
        repeat (30) begin step(); if (cmd_valid === 1'b1) nv++; end
        chk("t3_no_valid_after_err", nv, 32'd0);
        chk("t3_words_sent", got_q.size(), 32'd2);

        // Restart from ERR with stray start/done pulses sprinkled in
        withhold_n = -1; stray_en = 1; rand_delays = 1;
        do_start();
        st_e = edge_n + 1;
        step();
        chk("t4_dac_rst_low", {31'd0, dac_rst_n}, 32'd0);
        wait_for("t4_rise", 0, 50, e_rise);
        chk("t4_rst_hold_len", e_rise - st_e, 32'd4);
        wait_for("t4_valid", 1, 50, e_v);
        chk("t4_pwrup_len", e_v - e_rise, 32'd8);
        wait_for("t4_done", 2, 300, e_end);
        check_words("t4_words", 3);

        // Reset while a command is being offered
        stray_en = 0; rand_delays = 0; rdy_delay = 100;
        do_start();
        wait_for("t5_valid", 1, 50, e_v);
        step();
        do_rst(1);
        step();
        chk("t5_valid_dropped", {31'd0, cmd_valid}, 32'd0);
        chk("t5_dac_rst_low", {31'd0, dac_rst_n}, 32'd0);
        rdy_delay = 0; rand_delays = 1;
        wait_for("t5_rise", 0, 50, e_rise);
        chk("t5_rst_hold_len", e_rise - r0, 32'd4);
        wait_for("t5_done", 2, 300, e_end);
        check_words("t5_words", 3);

        // Random sequences, some with a withheld completion
        for (int k = 0; k < 6; k++) begin
            stray_en = 1'($urandom_range(0, 1));
            withhold_n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2)) : -1;
            do_start();
            wait_for("rand_end", 4, 400, e_end);
            if (withhold_n < 0) begin
                chk("rand_init_done", {31'd0, init_done}, 32'd1);
                check_words("rand_words", 3);
            end else begin
                chk("rand_init_err", {31'd0, init_err}, 32'd1);
                chk("rand_words_sent", got_q.size(), withhold_n + 1);
            end
        end

        step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
